// File: rtl/image_filter3x3.sv
// image_filter3x3: 3x3 gradient filter over a raster pixel stream.
// Two line buffers feed a 3x3 window; a three-stage pipeline produces
// bypass, |Gx|, |Gy| or |Gx|+|Gy| per pixel, centred one row/column back.
module image_filter3x3 #(
  parameter int unsigned DW     = 12,
  parameter int unsigned LINE_W = 1280,
  parameter int unsigned SHIFT  = 2
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic [15:0]   iX_Cont,
  input  logic [15:0]   iY_Cont,
  input  logic [1:0]    iMODE,
  output logic          oDVAL,
  output logic [DW-1:0] oDATA,
  output logic [15:0]   oX_Cont,
  output logic [15:0]   oY_Cont
);

  localparam int unsigned AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned GW = DW + 3;  // signed gradient width
  localparam int unsigned MW = DW + 4;  // width of |Gx|+|Gy|
  localparam logic [MW-1:0] SAT_MAX = MW'({DW{1'b1}});

  // Input decode
  logic          in_range;
  logic          frame_start;
  logic [AW-1:0] addr;
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;
  logic [1:0]    mode_q;
  logic [1:0]    mode_sel;

  // Line buffers and window
  logic [DW-1:0] lb0 [LINE_W];
  logic [DW-1:0] lb1 [LINE_W];
  logic [DW-1:0] win [3][3];

  // Stage 1 side-band
  logic          s1_valid;
  logic          s1_mask;
  logic [1:0]    s1_mode;
  logic [15:0]   s1_x;
  logic [15:0]   s1_y;

  // Stage 2
  logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic                 s2_valid;
  logic                 s2_mask;
  logic [1:0]           s2_mode;
  logic [15:0]          s2_x;
  logic [15:0]          s2_y;
  logic [DW-1:0]        s2_p11;
  logic signed [GW-1:0] s2_gx;
  logic signed [GW-1:0] s2_gy;

  // Stage 3
  logic [GW-1:0] abs_gx, abs_gy;
  logic [MW-1:0] mag;
  logic [MW-1:0] mag_sh;
  logic [DW-1:0] sat;
  logic [DW-1:0] result;

  assign addr        = iX_Cont[AW-1:0];
  assign in_range    = (32'(iX_Cont) < LINE_W);
  assign frame_start = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  // The mode sampled at a frame start already governs that first pixel.
  assign mode_sel    = frame_start ? iMODE : mode_q;

  // Out-of-range columns read as zero; their output is masked anyway.
  assign lb0_rd = in_range ? lb0[addr] : '0;
  assign lb1_rd = in_range ? lb1[addr] : '0;

  // Line buffers: not reset, border masking hides stale contents.
  always_ff @(posedge iCLK) begin
    if (iDVAL && in_range) begin
      lb1[addr] <= lb0_rd;
      lb0[addr] <= iDATA;
    end
  end

  // Window shift: column 2 takes {two rows up, one row up, current}.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= iDATA;
    end
  end

  // Stage 1 side-band: valid, centre coordinates, border mask, frame mode.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_valid <= 1'b0;
      s1_mask  <= 1'b0;
      s1_mode  <= 2'd0;
      s1_x     <= 16'd0;
      s1_y     <= 16'd0;
      mode_q   <= 2'd0;
    end else begin
      s1_valid <= iDVAL;
      if (iDVAL) begin
        s1_x    <= iX_Cont - 16'd1;
        s1_y    <= iY_Cont - 16'd1;
        s1_mask <= (iX_Cont < 16'd2) || (iY_Cont < 16'd2) || !in_range;
        s1_mode <= mode_sel;
      end
      if (frame_start) begin
        mode_q <= iMODE;
      end
    end
  end

  // Weighted column/row sums; each fits DW+2 bits unsigned, so the
  // DW+3 bit difference cannot overflow.
  assign gx_pos = GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]);
  assign gx_neg = GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]);
  assign gy_pos = GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]);
  assign gy_neg = GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]);

  // Stage 2 register: gradients plus the bypass pixel.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s2_valid <= 1'b0;
      s2_mask  <= 1'b0;
      s2_mode  <= 2'd0;
      s2_x     <= 16'd0;
      s2_y     <= 16'd0;
      s2_p11   <= '0;
      s2_gx    <= '0;
      s2_gy    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mask <= s1_mask;
        s2_mode <= s1_mode;
        s2_x    <= s1_x;
        s2_y    <= s1_y;
        s2_p11  <= win[1][1];
        s2_gx   <= gx_pos - gx_neg;
        s2_gy   <= gy_pos - gy_neg;
      end
    end
  end

  // Magnitudes never exceed 4*(2^DW-1), so they fit GW bits unsigned.
  assign abs_gx = s2_gx[GW-1] ? (~s2_gx + GW'(1)) : s2_gx;
  assign abs_gy = s2_gy[GW-1] ? (~s2_gy + GW'(1)) : s2_gy;

  // Magnitude select for the gradient modes.
  always_comb begin
    mag = '0;
    case (s2_mode)
      2'd1:    mag = MW'(abs_gx);
      2'd2:    mag = MW'(abs_gy);
      default: mag = MW'(abs_gx) + MW'(abs_gy);
    endcase
  end

  assign mag_sh = mag >> SHIFT;
  assign sat    = (mag_sh > SAT_MAX) ? {DW{1'b1}} : mag_sh[DW-1:0];

  // Final pixel value: border/out-of-range forces zero.
  always_comb begin
    result = '0;
    if (!s2_mask) begin
      result = (s2_mode == 2'd0) ? s2_p11 : sat;
    end
  end

  // Output register; data and coordinates hold while no pixel emerges.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDVAL   <= 1'b0;
      oDATA   <= '0;
      oX_Cont <= 16'd0;
      oY_Cont <= 16'd0;
    end else begin
      oDVAL <= s2_valid;
      if (s2_valid) begin
        oDATA   <= result;
        oX_Cont <= s2_x;
        oY_Cont <= s2_y;
      end
    end
  end

endmodule

// File: doc/image_filter3x3.md
IMAGE_FILTER3X3 -- requirements
Module: image_filter3x3

Interface
REQ-001 SHALL have parameter DW, default 12, pixel data width.
REQ-002 SHALL have parameter LINE_W, default 1280, maximum pixels per line held in the line buffers.
REQ-003 SHALL have parameter SHIFT, default 2, right-shift applied to gradient results before saturation.
REQ-004 Ports SHALL be as follows; the clock is iCLK and the reset is iRST_N, and reset is asynchronous and active-low:
- iCLK  in  1  pixel clock; all state updates on its rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iDVAL  in  1  input pixel valid.
- iDATA  in  DW  input pixel sample.
- iX_Cont  in  16  column of iDATA.
- iY_Cont  in  16  row of iDATA.
- iMODE  in  2  filter select: 0 bypass, 1 |Gx|, 2 |Gy|, 3 |Gx|+|Gy|.
- oDVAL  out  1  output pixel valid.
- oDATA  out  DW  filtered pixel.
- oX_Cont  out  16  column of the output (window centre).
- oY_Cont  out  16  row of the output (window centre).

Function
REQ-005 SHALL accept a pixel on every rising edge where iDVAL=1, with no backpressure; cycles where iDVAL=0 SHALL NOT alter the window or the line buffers.
REQ-006 SHALL hold two LINE_W-deep line buffers indexed by iX_Cont. On an accepted pixel it SHALL read lb0[x] and lb1[x], then write lb1[x]<=old lb0[x] and lb0[x]<=iDATA. A read that coincides with a write SHALL return the old data.
REQ-007 SHALL hold a 3x3 window p[r][c] (r,c = 0..2, with r=2 the current row and c=2 the newest column). Each accepted pixel SHALL shift columns left and load column 2 with {lb1[x], lb0[x], iDATA}.
REQ-008 SHALL compute the gradients as follows:
- Gx = (p02+2p12+p22) - (p00+2p10+p20)
- Gy = (p20+2p21+p22) - (p00+2p01+p02)
- Both are signed, DW+3 bits; the mode 3 sum is DW+4 bits; there SHALL be no intermediate overflow.
REQ-009 The mode result SHALL be:
- mode 0: p11.
- modes 1-3: the selected magnitude >> SHIFT, saturated to 2^DW-1.
REQ-010 SHALL be a three-stage pipeline:
- S1: line-buffer read and window shift.
- S2: gradient sums.
- S3: abs, shift, saturate and output register.
- An accepted pixel at edge k SHALL produce oDVAL=1 at edge k+3, exactly once.
- Gaps in iDVAL SHALL be reproduced on oDVAL.
REQ-011 For accepted pixel (x,y), the output SHALL carry oX_Cont=x-1 and oY_Cont=y-1, modulo 2^16 (x=0 gives 0xFFFF).
REQ-012 Border rule: if x<2 or y<2, oDATA SHALL be 0 in all modes while oDVAL is still asserted.
REQ-013 Out-of-range rule: if x>=LINE_W, the line buffers SHALL NOT be written, oDATA SHALL be 0, and oDVAL SHALL still be asserted.
REQ-014 A frame start occurs when iDVAL=1 and iX_Cont=0 and iY_Cont=0. iMODE SHALL be latched only at a frame start, and the latched value SHALL apply to that same pixel's output. A change of iMODE mid-frame SHALL have no effect until the next frame start.
REQ-015 oDATA, oX_Cont and oY_Cont SHALL hold their last values while oDVAL=0.

Reset
REQ-016 While iRST_N=0:
- oDVAL, oDATA, oX_Cont, oY_Cont, the window, the pipeline valid bits and the latched mode SHALL all be 0, asynchronously.
- Line-buffer contents are not reset; REQ-012 masks them.
REQ-017 After iRST_N rises, oDVAL SHALL stay 0 until 3 edges after the first accepted pixel.
REQ-018 A reset mid-frame SHALL discard all in-flight pixels, with no partial output after release.

Verification
REQ-019 Flat field: 16x8 frame with every pixel = 100.
- Mode 0: interior outputs = 100.
- Modes 1-3: interior outputs = 0.
- Border outputs = 0.
REQ-020 Vertical edge: pixels with x<8 = 0 and x>=8 = 400, mode 1, DW=12, SHIFT=2.
- Outputs with oX_Cont=7 and 8 = 400; all other interior outputs = 0.
- Mode 2 gives 0 everywhere.
REQ-021 Saturation: pixels with x>=8 and y>=8 = 4095, otherwise 0, mode 3.
- Output at (8,8) = 4095 (raw sum 24570>>2 = 6142, clipped).
REQ-022 Latency and gaps: iDVAL pattern 1,0,0,1,1.
- oDVAL = 0,0,0,1,0,0,1,1 starting from the first input edge.
- oX_Cont and oY_Cont = input-1.
- x=0 reports 0xFFFF.
REQ-023 Mode timing:
- iMODE switched 0->1 at mid-frame: outputs stay in bypass until the next (0,0) pixel.
- That (0,0) pixel and all later pixels use mode 1.
REQ-024 Reset mid-frame: pull iRST_N low at row 5.
- All outputs go to 0 immediately.
- After release, restart at (0,0): the first oDVAL appears 3 edges later with oDATA=0 (border).
